uart_rx_packer: RTL and testbench

//  Receive-side counterpart of the UART TX word unpacker: collects bytes from the UART RX core, packs

---
 rtl/uart_rx_packer_pkg.sv | 18 +
 rtl/uart_word_fifo.sv | 45 ++++
 rtl/uart_rx_packer.sv | 107 ++++++++++
 tb/tb_uart_rx_packer.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_packer_pkg.sv
// Shared UART RX packer types: packer state encoding and the FIFO entry layout.
package uart_rx_packer_pkg;

  localparam int BYTES_PER_WORD = 4;
  localparam int ENTRY_W        = 35;

  typedef enum logic {
    RX_IDLE    = 1'b0,
    RX_COLLECT = 1'b1
  } rx_state_e;

  // num holds 1..4 valid bytes; data is MSB-first with unused low bytes zero
  typedef struct packed {
    logic [2:0]  num;
    logic [31:0] data;
  } rx_entry_t;

endpackage

// File: rtl/uart_word_fifo.sv
// Synchronous first-word-fall-through FIFO; pointers carry one extra wrap bit for level.
module uart_word_fifo #(
  parameter int WIDTH = 35,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign level   = wr_ptr - rd_ptr;
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (level == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  // a pop in the same cycle frees the slot a full FIFO needs
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  assign pop_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/uart_rx_packer.sv
// Packs received UART bytes MSB-first into 32-bit words, flushing partial words after an idle gap.
module uart_rx_packer
  import uart_rx_packer_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int IDLE_CYCLES = 4340
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [7:0]             i_rx_data,
  input  logic                   i_rx_valid,
  input  logic                   i_rx_err,
  output logic [31:0]            o_rx_data,
  output logic [31:0]            o_rx_num,
  output logic                   o_rx_valid,
  input  logic                   i_rx_ack,
  output logic [$clog2(DEPTH):0] o_level,
  output logic                   o_busy,
  output logic                   o_overflow,
  output logic                   o_frame_err,
  input  logic                   i_clear_err
);
  localparam int TW = $clog2(IDLE_CYCLES + 1);
  localparam logic [TW-1:0] TMAX = TW'(IDLE_CYCLES - 1);

  rx_state_e   state, state_nxt;
  logic [2:0]  byte_cnt;
  logic [31:0] word, word_nxt;
  logic [TW-1:0] timer;
  logic        byte_ok, timeout, push, full, empty, drop;
  rx_entry_t   push_entry, head;

  assign byte_ok  = i_rx_valid & ~i_rx_err;
  assign timeout  = (state == RX_COLLECT) && (timer == TMAX) && !byte_ok;
  assign word_nxt = word | ({i_rx_data, 24'h0} >> {byte_cnt[1:0], 3'b000});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RX_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RX_IDLE:    if (byte_ok) state_nxt = RX_COLLECT;
      RX_COLLECT: if ((byte_ok && byte_cnt == 3'd3) || timeout) state_nxt = RX_IDLE;
      default:    state_nxt = RX_IDLE;
    endcase
  end

  always_comb begin
    push       = (state == RX_COLLECT) && ((byte_ok && byte_cnt == 3'd3) || timeout);
    push_entry = byte_ok ? rx_entry_t'{num: 3'd4, data: word_nxt}
                         : rx_entry_t'{num: byte_cnt, data: word};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word     <= '0;
      byte_cnt <= '0;
      timer    <= '0;
    end else if (push) begin
      word     <= '0;
      byte_cnt <= '0;
      timer    <= '0;
    end else if (byte_ok) begin
      word     <= word_nxt;
      byte_cnt <= byte_cnt + 3'd1;
      timer    <= '0;
    end else if (state == RX_COLLECT) begin
      timer    <= timer + 1'b1;
    end
  end

  assign drop = push & full & ~(i_rx_ack & ~empty);

  // set beats clear when both land in the same cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_overflow  <= 1'b0;
      o_frame_err <= 1'b0;
    end else begin
      if (drop)                        o_overflow  <= 1'b1;
      else if (i_clear_err)            o_overflow  <= 1'b0;
      if (i_rx_valid && i_rx_err)      o_frame_err <= 1'b1;
      else if (i_clear_err)            o_frame_err <= 1'b0;
    end
  end

  uart_word_fifo #(.WIDTH(ENTRY_W), .DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_entry),
    .pop       (i_rx_ack),
    .pop_data  (head),
    .full      (full),
    .empty     (empty),
    .level     (o_level)
  );

  assign o_rx_valid = ~empty;
  assign o_rx_data  = head.data;
  assign o_rx_num   = {29'd0, head.num};
  assign o_busy     = (state != RX_IDLE);

endmodule

// File: tb/tb_uart_rx_packer.sv
// Randomized and directed bench for uart_rx_packer against a queue-based byte/word model.
module tb_uart_rx_packer;
  localparam int DEPTH = 4;
  localparam int IC    = 16;

  logic        clk = 0, rst = 1;
  logic [7:0]  rx_data = 0;
  logic        rx_valid = 0, rx_err = 0, rx_ack = 0, clear_err = 0;
  logic [31:0] o_rx_data, o_rx_num;
  logic        o_rx_valid, o_busy, o_overflow, o_frame_err;
  logic [$clog2(DEPTH):0] o_level;

  int n_cmp = 0, n_bad = 0;

  typedef struct { int num; logic [31:0] data; } ent_t;
  ent_t       mq[$];
  logic [7:0] pb[$];
  int         idle;
  bit         m_ovf, m_ferr;

  uart_rx_packer #(.DEPTH(DEPTH), .IDLE_CYCLES(IC)) dut (
    .clk(clk), .rst(rst), .i_rx_data(rx_data), .i_rx_valid(rx_valid), .i_rx_err(rx_err),
    .o_rx_data(o_rx_data), .o_rx_num(o_rx_num), .o_rx_valid(o_rx_valid), .i_rx_ack(rx_ack),
    .o_level(o_level), .o_busy(o_busy), .o_overflow(o_overflow), .o_frame_err(o_frame_err),
    .i_clear_err(clear_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic ent_t pack_model();
    ent_t e;
    e.num  = pb.size();
    e.data = 0;
    for (int i = 0; i < pb.size(); i++) e.data = e.data + (32'(pb[i]) << (8 * (3 - i)));
    return e;
  endfunction

  task automatic model_reset();
    mq.delete(); pb.delete(); idle = 0; m_ovf = 0; m_ferr = 0;
  endtask

  task automatic model_edge(input bit v, input logic [7:0] d, input bit e, input bit ack, input bit clr);
    bit   pop  = ack && mq.size() > 0;
    bit   full = mq.size() == DEPTH;
    bit   have = 0;
    ent_t ne;
    if (v && !e) begin
      pb.push_back(d); idle = 0;
      if (pb.size() == 4) begin ne = pack_model(); have = 1; end
    end else if (pb.size() > 0) begin
      idle++;
      if (idle == IC) begin ne = pack_model(); have = 1; end
    end
    if (have) begin pb.delete(); idle = 0; end
    if (clr) begin m_ovf = 0; m_ferr = 0; end
    if (v && e) m_ferr = 1;
    if (pop) void'(mq.pop_front());
    if (have) begin
      if (full && !pop) m_ovf = 1;
      else mq.push_back(ne);
    end
  endtask

  task automatic check_all();
    chk("valid", 32'(o_rx_valid), 32'(mq.size() > 0));
    chk("level", 32'(o_level), mq.size());
    chk("busy", 32'(o_busy), 32'(pb.size() > 0));
    chk("overflow", 32'(o_overflow), 32'(m_ovf));
    chk("frame_err", 32'(o_frame_err), 32'(m_ferr));
    if (mq.size() > 0) begin
      chk("head_data", o_rx_data, mq[0].data);
      chk("head_num", o_rx_num, mq[0].num);
    end
  endtask

  task automatic step(input bit v, input logic [7:0] d, input bit e, input bit ack, input bit clr);
    rx_valid = v; rx_data = d; rx_err = e; rx_ack = ack; clear_err = clr;
    @(posedge clk);
    model_edge(v, d, e, ack, clr);
    #1;
    rx_valid = 0; rx_err = 0; rx_ack = 0; clear_err = 0;
    check_all();
  endtask

  task automatic send_byte(input logic [7:0] d);
    step(1, d, 0, 0, 0);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) send_byte(w[8*i +: 8]);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_data"}, o_rx_data, 0);
    chk({tag, "_num"}, o_rx_num, 0);
    chk({tag, "_valid"}, 32'(o_rx_valid), 0);
    chk({tag, "_level"}, 32'(o_level), 0);
    chk({tag, "_busy"}, 32'(o_busy), 0);
    chk({tag, "_ovf"}, 32'(o_overflow), 0);
    chk({tag, "_ferr"}, 32'(o_frame_err), 0);
  endtask

  task automatic do_reset();
    #2 rst = 1;
    model_reset();
    #1 check_zero("rst");
    @(posedge clk); #1 rst = 0;
  endtask

  task automatic drain();
    for (int k = 0; k < DEPTH + 2 && mq.size() > 0; k++) step(0, 0, 0, 1, 0);
  endtask

  initial begin
    model_reset();
    #1 check_zero("por");
    @(posedge clk); #1 rst = 0;

    // full 4-byte word, valid one clock after the 4th strobe
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    chk("w1_pre_valid", 32'(o_rx_valid), 0);
    send_byte(8'h44);
    chk("w1_valid", 32'(o_rx_valid), 1);
    chk("w1_data", o_rx_data, 32'h11223344);
    chk("w1_num", o_rx_num, 4);
    drain();

    // partial word flushed by idle timeout
    send_byte(8'hAA); send_byte(8'hBB);
    repeat (IC) step(0, 0, 0, 0, 0);
    chk("w2_data", o_rx_data, 32'hAABB0000);
    chk("w2_num", o_rx_num, 2);
    chk("w2_busy", 32'(o_busy), 0);
    drain();

    // overflow: DEPTH+1 words without ack
    for (int k = 0; k <= DEPTH; k++) send_word({4{8'(8'h10 * (k + 1))}});
    chk("ovf_level", 32'(o_level), DEPTH);
    chk("ovf_flag", 32'(o_overflow), 1);
    for (int k = 0; k < DEPTH; k++) begin
      chk("ovf_order", o_rx_data, {4{8'(8'h10 * (k + 1))}});
      step(0, 0, 0, 1, 0);
    end
    step(0, 0, 0, 0, 1);
    chk("ovf_clear", 32'(o_overflow), 0);

    // errored byte dropped from the word
    send_byte(8'h01);
    step(1, 8'h02, 1, 0, 0);
    send_byte(8'h03); send_byte(8'h04); send_byte(8'h05);
    chk("ferr_data", o_rx_data, 32'h01030405);
    chk("ferr_flag", 32'(o_frame_err), 1);
    step(0, 0, 0, 1, 1);
    chk("ferr_clear", 32'(o_frame_err), 0);
    // clear with simultaneous error keeps the flag set
    step(1, 8'h77, 1, 0, 1);
    chk("ferr_set_wins", 32'(o_frame_err), 1);
    step(0, 0, 0, 0, 1);

    // push and pop together on a full FIFO
    for (int k = 0; k < DEPTH; k++) send_word(32'hC0C1C2C3 + k);
    send_byte(8'hD0); send_byte(8'hD1); send_byte(8'hD2);
    step(1, 8'hD3, 0, 1, 0);
    chk("full_pp_level", 32'(o_level), DEPTH);
    chk("full_pp_ovf", 32'(o_overflow), 0);
    drain();

    // reset mid-word, then a fresh word
    send_byte(8'h5A); send_byte(8'h5B); send_byte(8'h5C);
    do_reset();
    send_word(32'hE1E2E3E4);
    chk("fresh_data", o_rx_data, 32'hE1E2E3E4);
    chk("fresh_num", o_rx_num, 4);
    drain();

    // randomized traffic
    for (int it = 0; it < 3000; it++) begin
      if ($urandom_range(0, 60) == 0) begin
        repeat (IC + $urandom_range(0, 4)) step(0, 0, 0, $urandom_range(0, 7) == 0, 0);
      end else if ($urandom_range(0, 800) == 0) begin
        do_reset();
      end else begin
        step($urandom_range(0, 2) == 0, 8'($urandom), $urandom_range(0, 15) == 0,
             $urandom_range(0, 3) == 0, $urandom_range(0, 31) == 0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
